change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The module SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 The module SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 The module SHALL have port: refund_valid  input  1  refund request present.
REQ-004 The module SHALL have port: refund_amount  input  8  refund value in currency units.
REQ-005 The module SHALL have port: refund_ready  output  1  high only in IDLE; request accepted on a clock edge when refund_valid and refund_ready are both high.
REQ-006 The module SHALL have ports: empty_5, empty_10, empty_50  input  1 each  hopper has no coin of that value.
REQ-007 The module SHALL have port: coin_valid  output  1  coin request to the hopper.
REQ-008 The module SHALL have port: coin_type  output  2  2'b00=5, 2'b01=10, 2'b10=50; 2'b11 is never driven.
REQ-009 The module SHALL have port: coin_ack  input  1  hopper has dropped the requested coin.
REQ-010 The module SHALL have ports: done  output  1  one-cycle completion pulse; err  output  1  qualifies done, high means refund failed.
REQ-011 The module SHALL have ports: paid_total  output  8  units paid for the current or last request; shortfall  output  8  units left unpaid.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SELECT, ISSUE, DONE and FAULT.
REQ-013 On acceptance, remaining SHALL load refund_amount, paid_total and shortfall SHALL clear to 0, and the next state SHALL be SELECT.
REQ-014 If refund_amount mod 5 != 0, the block SHALL go to FAULT with no coin issued, paid_total 0 and shortfall equal to refund_amount.
REQ-015 In SELECT with remaining 0 (including a 0 request), the next state SHALL be DONE.
REQ-016 In SELECT, coin choice SHALL be greedy and use the empty flags sampled that cycle: 50 if remaining>=50 and !empty_50; else 10 if remaining>=10 and !empty_10; else 5 if !empty_5; else FAULT.
REQ-017 In ISSUE, coin_valid SHALL be 1 and coin_type SHALL be held stable until coin_ack.
REQ-018 On an edge with coin_valid and coin_ack high, remaining SHALL decrease by the coin value, paid_total SHALL increase by the coin value, and the next state SHALL be SELECT.
REQ-019 coin_ack while coin_valid is low SHALL be ignored.
REQ-020 Each coin SHALL cost at least 2 cycles (SELECT, then ISSUE), and the hopper handshake SHALL have no combinational path from coin_ack to coin_valid.
REQ-021 DONE SHALL assert done=1 and err=0 for one cycle, set shortfall=0, and then go to IDLE.
REQ-022 FAULT SHALL assert done=1 and err=1 for one cycle, set shortfall=remaining, and then go to IDLE.
REQ-023 paid_total and shortfall SHALL hold their values in IDLE until the next acceptance.
REQ-024 refund_valid outside IDLE SHALL be ignored; the requester holds refund_valid until it is accepted.
REQ-025 Arithmetic SHALL be 8-bit unsigned; subtraction SHALL never underflow, because coin value <= remaining per REQ-016.

Reset
REQ-026 While rst is high at a clock edge, the state SHALL become IDLE and remaining, paid_total and shortfall SHALL become 0.
REQ-027 During reset, coin_valid, done and err SHALL be 0, coin_type SHALL be 2'b00, and refund_ready SHALL be 0.
REQ-028 refund_ready SHALL be 1 from the first edge after rst deasserts.
REQ-029 Reset during ISSUE SHALL drop coin_valid at that edge; the partial payout SHALL be discarded with no done pulse.

Configuration
REQ-030 With macro COIN_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in ISSUE, with parameter ACK_TIMEOUT (default 1000) as the limit.
REQ-031 With COIN_TIMEOUT_EN defined, if the counter reaches ACK_TIMEOUT without coin_ack, the next state SHALL be FAULT and shortfall SHALL equal remaining.
REQ-032 With COIN_TIMEOUT_EN undefined, ISSUE SHALL wait indefinitely for coin_ack and no counter SHALL be built.

Verification
REQ-033 Refund 35 with all hoppers full and coin_ack 1 cycle after coin_valid -> coins 10,10,10,5, then done=1, err=0, paid_total=35, shortfall=0.
REQ-034 Refund 65 with all hoppers full -> coins 50,10,5, then done=1, err=0, paid_total=65.
REQ-035 Refund 20 with empty_10=1 -> coins 5,5,5,5, then paid_total=20, err=0.
REQ-036 Refund 15 with empty_5=1 -> coin 10, then done=1, err=1, paid_total=10, shortfall=5.
REQ-037 Refund 17 -> no coin_valid, then done=1, err=1, paid_total=0, shortfall=17; refund 0 -> done=1, err=0 two cycles after acceptance.
REQ-038 Assert rst mid-ISSUE during a refund of 30 -> coin_valid=0, all counts 0, refund_ready=1 after release; with COIN_TIMEOUT_EN and ACK_TIMEOUT=8, withholding coin_ack -> err=1 after 8 cycles.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Refund-request and coin-hopper signal bundle for change_dispenser.
// master = requester/hopper side, slave = the dispenser itself.
interface change_dispenser_if;
    logic       refund_valid;
    logic [7:0] refund_amount;
    logic       refund_ready;
    logic       empty_5;
    logic       empty_10;
    logic       empty_50;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ack;
    logic       done;
    logic       err;
    logic [7:0] paid_total;
    logic [7:0] shortfall;

    modport master (
        output refund_valid, refund_amount, empty_5, empty_10, empty_50, coin_ack,
        input  refund_ready, coin_valid, coin_type, done, err, paid_total, shortfall
    );

    modport slave (
        input  refund_valid, refund_amount, empty_5, empty_10, empty_50, coin_ack,
        output refund_ready, coin_valid, coin_type, done, err, paid_total, shortfall
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin refund sequencer (50/10/5) driving a coin hopper one coin at a time.
// Optional macro COIN_TIMEOUT_EN adds an ISSUE-state ack timeout (parameter ACK_TIMEOUT).
module change_dispenser (
    input  logic                     clk,
    input  logic                     rst,
    change_dispenser_if.slave        bus
);
`ifdef COIN_TIMEOUT_EN
    parameter int unsigned ACK_TIMEOUT = 1000;
`endif

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, FAULT} state_t;

    // Index 0/1/2 matches coin_type encoding 5/10/50.
    localparam logic [2:0][7:0] COIN_VAL = {8'd50, 8'd10, 8'd5};

    state_t     state_reg;
    logic [7:0] remaining_reg;
    logic [7:0] paid_reg;
    logic [7:0] short_reg;
    logic       coin_valid_reg;
    logic [1:0] coin_type_reg;
    logic       done_reg;
    logic       err_reg;
    logic       ready_reg;
`ifdef COIN_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;
`endif

    logic [2:0] empty_vec;
    logic [2:0] coin_ok;
    logic [1:0] pick_type;

    assign empty_vec = {bus.empty_50, bus.empty_10, bus.empty_5};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coin_ok
            assign coin_ok[gi] = (remaining_reg >= COIN_VAL[gi]) && !empty_vec[gi];
        end
    endgenerate

    // Largest usable denomination wins.
    always_comb begin
        pick_type = 2'b00;
        if (coin_ok[2])
            pick_type = 2'b10;
        else if (coin_ok[1])
            pick_type = 2'b01;
    end

    function automatic logic [7:0] coin_value(input logic [1:0] ct);
        case (ct)
            2'b10:   return 8'd50;
            2'b01:   return 8'd10;
            default: return 8'd5;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            remaining_reg  <= 8'd0;
            paid_reg       <= 8'd0;
            short_reg      <= 8'd0;
            coin_valid_reg <= 1'b0;
            coin_type_reg  <= 2'b00;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            ready_reg      <= 1'b0;
`ifdef COIN_TIMEOUT_EN
            wait_cnt_reg   <= 16'd0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (bus.refund_valid && ready_reg) begin
                        remaining_reg <= bus.refund_amount;
                        paid_reg      <= 8'd0;
                        short_reg     <= 8'd0;
                        ready_reg     <= 1'b0;
                        state_reg     <= SELECT;
                    end
                end
                SELECT: begin
                    // Remaining stays a multiple of 5 after the first check, so
                    // only an unpayable request can trip the modulo test.
                    if ((remaining_reg % 8'd5) != 8'd0) begin
                        state_reg <= FAULT;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                        short_reg <= remaining_reg;
                    end else if (remaining_reg == 8'd0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        short_reg <= 8'd0;
                    end else if (coin_ok != 3'b000) begin
                        state_reg      <= ISSUE;
                        coin_valid_reg <= 1'b1;
                        coin_type_reg  <= pick_type;
`ifdef COIN_TIMEOUT_EN
                        wait_cnt_reg   <= 16'd0;
`endif
                    end else begin
                        state_reg <= FAULT;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                        short_reg <= remaining_reg;
                    end
                end
                ISSUE: begin
                    if (bus.coin_ack) begin
                        remaining_reg  <= remaining_reg - coin_value(coin_type_reg);
                        paid_reg       <= paid_reg + coin_value(coin_type_reg);
                        coin_valid_reg <= 1'b0;
                        state_reg      <= SELECT;
                    end
`ifdef COIN_TIMEOUT_EN
                    else if (wait_cnt_reg == 16'(ACK_TIMEOUT - 1)) begin
                        coin_valid_reg <= 1'b0;
                        state_reg      <= FAULT;
                        done_reg       <= 1'b1;
                        err_reg        <= 1'b1;
                        short_reg      <= remaining_reg;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
`endif
                end
                DONE, FAULT: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.refund_ready = ready_reg;
    assign bus.coin_valid   = coin_valid_reg;
    assign bus.coin_type    = coin_type_reg;
    assign bus.done         = done_reg;
    assign bus.err          = err_reg;
    assign bus.paid_total   = paid_reg;
    assign bus.shortfall    = short_reg;
endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a denomination-count model,
// plus directed cases for faults, zero refunds and mid-issue reset.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if bus();

`ifdef COIN_TIMEOUT_EN
    change_dispenser #(.ACK_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    change_dispenser dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model results
    int m_coins[$];
    int m_paid, m_short;
    bit m_err;

    // Expectations used by the compare process
    int exp_q[$];
    int exp_paid, exp_short;
    bit exp_err;
    bit txn_active = 0;
    bit done_seen = 0;
    int accept_cyc, done_cyc;

    // Hopper behaviour knobs
    bit ack_hold = 0;
    bit ack_noise = 0;
    int ack_max = 0;
    int ack_wait = 0;
    int issue_cycles = 0;
    bit prev_valid = 0;
    logic [1:0] prev_type = 2'b00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pay as many of each denomination as fits, largest first; whatever is
    // left after the 5s (or an amount not divisible by 5) is unpaid.
    function automatic void run_model(input int amt, input bit e5, input bit e10, input bit e50);
        int r, n;
        m_coins.delete();
        if (amt % 5 != 0) begin
            m_paid = 0; m_short = amt; m_err = 1;
            return;
        end
        r = amt;
        n = e50 ? 0 : r / 50; repeat (n) m_coins.push_back(50); r -= 50 * n;
        n = e10 ? 0 : r / 10; repeat (n) m_coins.push_back(10); r -= 10 * n;
        n = e5  ? 0 : r / 5;  repeat (n) m_coins.push_back(5);  r -= 5 * n;
        m_paid = amt - r; m_short = r; m_err = (r != 0);
    endfunction

    function automatic int coin_code();
        int c = 0;
        foreach (m_coins[i]) c = c * 100 + m_coins[i];
        return c;
    endfunction

    // Hopper model and the single compare process.
    always @(negedge clk) begin
        if (bus.coin_valid) begin
            issue_cycles++;
            if (ack_hold)
                bus.coin_ack = 1'b0;
            else if (ack_wait == 0)
                bus.coin_ack = 1'b1;
            else begin
                bus.coin_ack = 1'b0;
                ack_wait--;
            end
        end else begin
            bus.coin_ack = ack_noise && ($urandom_range(0, 3) == 0);
            ack_wait = $urandom_range(0, ack_max);
        end

        if (!rst) begin
            if (bus.coin_valid) begin
                chk("ready_during_issue", bus.refund_ready, 0);
                if (prev_valid) chk("coin_type_stable", bus.coin_type, prev_type);
                if (bus.coin_ack)
                    chk("coin_type", bus.coin_type, exp_q.size() > 0 ? exp_q.pop_front() : 3);
            end
            prev_valid = bus.coin_valid;
            prev_type  = bus.coin_type;
            if (bus.done) begin
                if (!txn_active) chk("spurious_done", bus.done, 0);
                else begin
                    chk("err", bus.err, exp_err);
                    chk("paid_total", bus.paid_total, exp_paid);
                    chk("shortfall", bus.shortfall, exp_short);
                    chk("coins_left", exp_q.size(), 0);
                    done_cyc = cyc;
                    done_seen = 1;
                    txn_active = 0;
                end
            end
        end else begin
            prev_valid = 0;
        end
    end

    task automatic start_refund(input int amt, input bit e5, input bit e10, input bit e50);
        bit accepted = 0;
        bus.empty_5 = e5; bus.empty_10 = e10; bus.empty_50 = e50;
        run_model(amt, e5, e10, e50);
        exp_q.delete();
        foreach (m_coins[i]) exp_q.push_back(m_coins[i] == 50 ? 2 : (m_coins[i] == 10 ? 1 : 0));
        exp_paid = m_paid; exp_short = m_short; exp_err = m_err;
        done_seen = 0;
        txn_active = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.refund_amount = 8'(amt);
            bus.refund_valid  = 1'b1;
            if (bus.refund_ready) begin
                accepted = 1;
                accept_cyc = cyc;
                break;
            end
        end
        if (!accepted) chk("accept_timeout", bus.refund_ready, 1);
        @(posedge clk);
        #1 bus.refund_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
        if (!done_seen) chk("done_timeout", bus.done, 1);
    endtask

    task automatic refund(input int amt, input bit e5, input bit e10, input bit e50);
        start_refund(amt, e5, e10, e50);
        wait_done();
        $display("refund %0d empty(5,10,50)=%0b%0b%0b -> paid %0d short %0d err %0b",
                 amt, e5, e10, e50, bus.paid_total, bus.shortfall, bus.err);
    endtask

    initial begin
        bus.refund_valid = 1'b0;
        bus.refund_amount = 8'd0;
        bus.empty_5 = 1'b0; bus.empty_10 = 1'b0; bus.empty_50 = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.refund_ready, 0);
        chk("rst_coin_valid", bus.coin_valid, 0);
        chk("rst_coin_type", bus.coin_type, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_paid", bus.paid_total, 0);
        chk("rst_short", bus.shortfall, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.refund_ready, 1);

        // Pin the model with hand-worked cases
        run_model(35, 0, 0, 0); chk("model35_coins", coin_code(), 10101005); chk("model35_paid", m_paid, 35);
        run_model(65, 0, 0, 0); chk("model65_coins", coin_code(), 501005);   chk("model65_paid", m_paid, 65);
        run_model(20, 0, 1, 0); chk("model20_coins", coin_code(), 5050505);  chk("model20_err", m_err, 0);
        run_model(15, 1, 0, 0); chk("model15_coins", coin_code(), 10);       chk("model15_short", m_short, 5);
        run_model(17, 0, 0, 0); chk("model17_coins", m_coins.size(), 0);     chk("model17_short", m_short, 17);

        // Directed refunds, hopper acks one cycle after coin_valid
        ack_max = 0; ack_noise = 0;
        refund(35, 0, 0, 0);
        refund(65, 0, 0, 0);
        refund(20, 0, 1, 0);
        refund(15, 1, 0, 0);
        refund(17, 0, 0, 0);
        chk("fault_latency", done_cyc - accept_cyc, 2);
        refund(0, 0, 0, 0);
        chk("zero_latency", done_cyc - accept_cyc, 2);
        chk("zero_err", bus.err, 0);
        repeat (2) @(negedge clk);
        chk("paid_held_idle", bus.paid_total, 0);

        // Reset in the middle of a coin issue
        ack_hold = 1;
        start_refund(30, 0, 0, 0);
        for (int i = 0; i < 20 && !bus.coin_valid; i++) @(negedge clk);
        chk("rst_test_in_issue", bus.coin_valid, 1);
        rst = 1'b1;
        txn_active = 0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_coin_valid", bus.coin_valid, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_paid", bus.paid_total, 0);
        chk("midrst_short", bus.shortfall, 0);
        chk("midrst_ready", bus.refund_ready, 0);
        rst = 1'b0;
        ack_hold = 0;
        @(negedge clk);
        chk("midrst_ready_after", bus.refund_ready, 1);
        repeat (4) @(negedge clk);
        $display("mid-issue reset: coin_valid %0b paid %0d ready %0b", bus.coin_valid, bus.paid_total, bus.refund_ready);

`ifdef COIN_TIMEOUT_EN
        // Withheld ack: ISSUE lasts ACK_TIMEOUT cycles, then FAULT
        ack_hold = 1;
        start_refund(30, 0, 0, 0);
        exp_q.delete(); exp_paid = 0; exp_short = 30; exp_err = 1;
        issue_cycles = 0;
        wait_done();
        chk("timeout_issue_cycles", issue_cycles, 8);
        $display("timeout: err %0b short %0d issue cycles %0d", bus.err, bus.shortfall, issue_cycles);
        ack_hold = 0;
`endif

        // Randomized refunds with random hopper latency and stray acks
        ack_noise = 1;
        for (int n = 0; n < 60; n++) begin
            int amt;
            ack_max = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) amt = $urandom_range(0, 255);
            else amt = 5 * $urandom_range(0, 51);
            refund(amt, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
